// File: rtl/mips_cpu.sv
// Single-issue MIPS-subset core with one branch delay slot and a CP0 external-interrupt path.
// Define MIPS_CPU_EXC_EN to enable the internal exceptions (RI, Ov, AdEL, AdES).
module mips_cpu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    output logic [31:0] macroscopic_pc,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    logic [31:0] r_pc, r_npc, r_sr, r_cause, r_epc;
    logic        r_in_bd;
    logic [31:0] r_grf [0:31];

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs_a, w_rt_a, w_rd_a, w_sa;
    logic [15:0] w_imm;
    logic [31:0] w_sext, w_zext, w_rs, w_rt, w_pc4, w_pc8, w_addr, w_lword, w_cp0_rd;
    logic [7:0]  w_lbyte;
    logic [15:0] w_lhalf;

    assign w_op   = i_inst_rdata[31:26];
    assign w_rs_a = i_inst_rdata[25:21];
    assign w_rt_a = i_inst_rdata[20:16];
    assign w_rd_a = i_inst_rdata[15:11];
    assign w_sa   = i_inst_rdata[10:6];
    assign w_fn   = i_inst_rdata[5:0];
    assign w_imm  = i_inst_rdata[15:0];
    assign w_sext = {{16{w_imm[15]}}, w_imm};
    assign w_zext = {16'h0, w_imm};
    assign w_rs   = r_grf[w_rs_a];
    assign w_rt   = r_grf[w_rt_a];
    assign w_pc4  = r_pc + 32'd4;
    assign w_pc8  = r_pc + 32'd8;
    assign w_addr = w_rs + w_sext;

    // Memory returns the aligned word; shift the addressed byte/half down to bit 0.
    assign w_lword = m_data_rdata >> {w_addr[1:0], 3'b000};
    assign w_lbyte = w_lword[7:0];
    assign w_lhalf = w_addr[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];

    always_comb begin
        case (w_rd_a)
            5'd12:   w_cp0_rd = r_sr;
            5'd13:   w_cp0_rd = r_cause;
            5'd14:   w_cp0_rd = r_epc;
            default: w_cp0_rd = 32'h0;
        endcase
    end

    logic        w_wr_en, w_br, w_taken, w_mtc0, w_eret;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data, w_target, w_wdata;
    logic [3:0]  w_be;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = w_rt_a;
        w_wr_data = 32'h0;
        w_br      = 1'b0;
        w_taken   = 1'b0;
        w_target  = w_pc4 + {w_sext[29:0], 2'b00};
        w_be      = 4'b0000;
        w_wdata   = w_rt;
        w_mtc0    = 1'b0;
        w_eret    = 1'b0;
        case (w_op)
            6'h00: begin
                w_wr_addr = w_rd_a;
                w_wr_en   = 1'b1;
                case (w_fn)
                    6'h20, 6'h21: w_wr_data = w_rs + w_rt;
                    6'h22, 6'h23: w_wr_data = w_rs - w_rt;
                    6'h24: w_wr_data = w_rs & w_rt;
                    6'h25: w_wr_data = w_rs | w_rt;
                    6'h27: w_wr_data = ~(w_rs | w_rt);
                    6'h2a: w_wr_data = {31'h0, $signed(w_rs) < $signed(w_rt)};
                    6'h2b: w_wr_data = {31'h0, w_rs < w_rt};
                    6'h00: w_wr_data = w_rt << w_sa;
                    6'h02: w_wr_data = w_rt >> w_sa;
                    6'h03: w_wr_data = $signed(w_rt) >>> w_sa;
                    6'h08: begin
                        w_wr_en = 1'b0; w_br = 1'b1; w_taken = 1'b1; w_target = w_rs;
                    end
                    6'h09: begin
                        w_br = 1'b1; w_taken = 1'b1; w_target = w_rs; w_wr_data = w_pc8;
                    end
                    default: w_wr_en = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin w_wr_en = 1'b1; w_wr_data = w_rs + w_sext; end
            6'h0a: begin w_wr_en = 1'b1; w_wr_data = {31'h0, $signed(w_rs) < $signed(w_sext)}; end
            6'h0c: begin w_wr_en = 1'b1; w_wr_data = w_rs & w_zext; end
            6'h0d: begin w_wr_en = 1'b1; w_wr_data = w_rs | w_zext; end
            6'h0f: begin w_wr_en = 1'b1; w_wr_data = {w_imm, 16'h0}; end
            6'h04: begin w_br = 1'b1; w_taken = (w_rs == w_rt); end
            6'h05: begin w_br = 1'b1; w_taken = (w_rs != w_rt); end
            6'h02, 6'h03: begin
                w_br      = 1'b1;
                w_taken   = 1'b1;
                w_target  = {w_pc4[31:28], i_inst_rdata[25:0], 2'b00};
                w_wr_en   = w_op[0];
                w_wr_addr = 5'd31;
                w_wr_data = w_pc8;
            end
            6'h23: begin w_wr_en = 1'b1; w_wr_data = m_data_rdata; end
            6'h21: begin w_wr_en = 1'b1; w_wr_data = {{16{w_lhalf[15]}}, w_lhalf}; end
            6'h25: begin w_wr_en = 1'b1; w_wr_data = {16'h0, w_lhalf}; end
            6'h20: begin w_wr_en = 1'b1; w_wr_data = {{24{w_lbyte[7]}}, w_lbyte}; end
            6'h24: begin w_wr_en = 1'b1; w_wr_data = {24'h0, w_lbyte}; end
            6'h2b: w_be = 4'b1111;
            6'h29: begin w_be = 4'b0011 << {w_addr[1], 1'b0}; w_wdata = {2{w_rt[15:0]}}; end
            6'h28: begin w_be = 4'b0001 << w_addr[1:0]; w_wdata = {4{w_rt[7:0]}}; end
            6'h10: begin
                if (w_rs_a == 5'h00) begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_cp0_rd;
                end else if (w_rs_a == 5'h04) begin
                    w_mtc0 = 1'b1;
                end else if (w_rs_a == 5'h10 && w_fn == 6'h18) begin
                    w_eret = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic       w_int_req, w_exc, w_trap;
    logic [4:0] w_exc_code;

    assign w_int_req = interrupt & r_sr[12] & r_sr[0] & ~r_sr[1];

`ifdef MIPS_CPU_EXC_EN
    logic w_ri, w_ov, w_adel, w_ades;
    always_comb begin
        w_ri   = !(w_op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                                6'h0c, 6'h0d, 6'h0f, 6'h10, 6'h20, 6'h21, 6'h23, 6'h24,
                                6'h25, 6'h28, 6'h29, 6'h2b});
        w_ov   = ((w_op == 6'h00 && w_fn == 6'h20) &&
                  (w_rs[31] == w_rt[31]) && (w_wr_data[31] != w_rs[31])) ||
                 ((w_op == 6'h00 && w_fn == 6'h22) &&
                  (w_rs[31] != w_rt[31]) && (w_wr_data[31] != w_rs[31])) ||
                 ((w_op == 6'h08) &&
                  (w_rs[31] == w_sext[31]) && (w_wr_data[31] != w_rs[31]));
        w_adel = ((w_op == 6'h23) && (w_addr[1:0] != 2'b00)) ||
                 ((w_op == 6'h21 || w_op == 6'h25) && w_addr[0]);
        w_ades = ((w_op == 6'h2b) && (w_addr[1:0] != 2'b00)) ||
                 ((w_op == 6'h29) && w_addr[0]);
        w_exc  = w_ri | w_ov | w_adel | w_ades;
        if (w_ri)        w_exc_code = 5'd10;
        else if (w_ov)   w_exc_code = 5'd12;
        else if (w_adel) w_exc_code = 5'd4;
        else if (w_ades) w_exc_code = 5'd5;
        else             w_exc_code = 5'd0;
    end
`else
    assign w_exc      = 1'b0;
    assign w_exc_code = 5'd0;
`endif

    // A trapped instruction is squashed: nothing it would write becomes visible.
    assign w_trap = w_int_req | w_exc;

    assign macroscopic_pc = r_pc;
    assign i_inst_addr    = r_pc;
    assign m_inst_addr    = r_pc;
    assign w_inst_addr    = r_pc;
    assign m_data_addr    = w_addr;
    assign m_data_wdata   = w_wdata;
    assign m_data_byteen  = (reset && !w_trap) ? w_be : 4'b0000;
    assign w_grf_we       = reset & ~w_trap & w_wr_en & (w_wr_addr != 5'd0);
    assign w_grf_addr     = w_wr_addr;
    assign w_grf_wdata    = w_wr_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_npc   <= RESET_PC + 32'd4;
            r_in_bd <= 1'b0;
            r_sr    <= 32'h0;
            r_cause <= 32'h0;
            r_epc   <= 32'h0;
            for (int i = 0; i < 32; i++) r_grf[i] <= 32'h0;
        end else begin
            r_cause[12] <= interrupt;
            if (w_trap) begin
                r_epc         <= r_in_bd ? r_pc - 32'd4 : r_pc;
                r_cause[31]   <= r_in_bd;
                r_cause[6:2]  <= w_int_req ? 5'd0 : w_exc_code;
                r_sr[1]       <= 1'b1;
                r_pc          <= HANDLER_PC;
                r_npc         <= HANDLER_PC + 32'd4;
                r_in_bd       <= 1'b0;
            end else if (w_eret) begin
                r_pc    <= r_epc;
                r_npc   <= r_epc + 32'd4;
                r_sr[1] <= 1'b0;
                r_in_bd <= 1'b0;
            end else begin
                r_pc    <= r_npc;
                r_npc   <= w_taken ? w_target : r_npc + 32'd4;
                r_in_bd <= w_br;
                if (w_mtc0 && w_rd_a == 5'd12) r_sr  <= w_rt;
                if (w_mtc0 && w_rd_a == 5'd14) r_epc <= w_rt;
                if (w_wr_en && w_wr_addr != 5'd0) r_grf[w_wr_addr] <= w_wr_data;
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed program bench for mips_cpu: instruction/data memories modelled here, trace ports checked per cycle.
module tb_mips_cpu;
    logic        clk = 1'b0;
    logic        reset, interrupt;
    logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata;
    logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_inst_addr;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata, w_inst_addr;

    logic [31:0] imem [0:4095];
    logic [31:0] dmem [0:4095];
    int n_chk = 0;
    int n_err = 0;

    mips_cpu dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .macroscopic_pc(macroscopic_pc), .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr)
    );

    always #5 clk = ~clk;

    assign i_inst_rdata = imem[i_inst_addr[13:2]];
    assign m_data_rdata = dmem[m_data_addr[13:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (m_data_byteen[b]) dmem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa, input logic [5:0] fn);
        return {op, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        imem[addr[13:2]] = word;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        put(32'h3000, enc_i(6'h0d, 5'd0, 5'd1, 16'h1234));          // ori  $1,$0,0x1234
        put(32'h3004, enc_i(6'h2b, 5'd0, 5'd1, 16'h0004));          // sw   $1,4($0)
        put(32'h3008, enc_i(6'h28, 5'd0, 5'd1, 16'h0007));          // sb   $1,7($0)
        put(32'h300c, enc_i(6'h04, 5'd0, 5'd0, 16'h000c));          // beq  -> 0x3040
        put(32'h3010, enc_i(6'h0d, 5'd0, 5'd3, 16'h0055));          // ori  $3 (delay slot)
        put(32'h3014, enc_i(6'h0d, 5'd0, 5'd4, 16'hdead));          // skipped
        put(32'h3018, enc_i(6'h04, 5'd0, 5'd0, 16'h0011));          // beq  -> 0x3060
        put(32'h301c, enc_i(6'h0d, 5'd0, 5'd6, 16'h0077));          // ori  $6 (delay slot)
        put(32'h3040, enc_i(6'h23, 5'd0, 5'd2, 16'h0004));          // lw   $2,4($0)
        put(32'h3044, enc_i(6'h0d, 5'd0, 5'd5, 16'h1401));          // ori  $5,$0,0x1401
        put(32'h3048, enc_r(6'h10, 5'd4, 5'd5, 5'd12, 5'd0, 6'h0)); // mtc0 $5,SR
        put(32'h304c, {6'h03, 26'h0000C06});                        // jal  0x3018
        put(32'h3050, enc_i(6'h0d, 5'd0, 5'd7, 16'h0099));          // ori  $7 (delay slot)
        put(32'h3060, enc_r(6'h10, 5'd0, 5'd11, 5'd12, 5'd0, 6'h0));// mfc0 $11,SR
        put(32'h3064, enc_r(6'h00, 5'd0, 5'd1, 5'd14, 5'd0, 6'h23));// subu $14,$0,$1
        put(32'h3068, enc_i(6'h2b, 5'd0, 5'd14, 16'h0008));         // sw   $14,8($0)
        put(32'h306c, enc_i(6'h20, 5'd0, 5'd15, 16'h0008));         // lb   $15,8($0)
        put(32'h3070, enc_i(6'h25, 5'd0, 5'd16, 16'h000a));         // lhu  $16,10($0)
        put(32'h3074, enc_r(6'h00, 5'd14, 5'd1, 5'd17, 5'd0, 6'h2a));// slt $17,$14,$1
        put(32'h3078, enc_r(6'h00, 5'd14, 5'd1, 5'd18, 5'd0, 6'h2b));// sltu $18,$14,$1
        put(32'h307c, enc_r(6'h00, 5'd0, 5'd14, 5'd19, 5'd4, 6'h03));// sra $19,$14,4
        put(32'h3080, enc_i(6'h0f, 5'd0, 5'd20, 16'h8000));         // lui  $20,0x8000
        put(32'h3084, enc_i(6'h2b, 5'd0, 5'd20, 16'h000c));         // sw   $20,12($0)
        put(32'h4180, enc_i(6'h2b, 5'd0, 5'd1, 16'h7f20));          // sw   $1,0x7F20($0)
        put(32'h4184, enc_r(6'h10, 5'd0, 5'd8, 5'd13, 5'd0, 6'h0)); // mfc0 $8,Cause
        put(32'h4188, enc_r(6'h10, 5'd0, 5'd9, 5'd14, 5'd0, 6'h0)); // mfc0 $9,EPC
        put(32'h418c, enc_r(6'h10, 5'd0, 5'd10, 5'd12, 5'd0, 6'h0));// mfc0 $10,SR
        put(32'h4190, 32'h4200_0018);                               // eret

        reset = 1'b0;
        interrupt = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", macroscopic_pc, 32'h3000);
        chk("rst_we", {31'h0, w_grf_we}, 32'h0);
        chk("rst_be", {28'h0, m_data_byteen}, 32'h0);

        reset = 1'b1;
        #1;
        chk("ori_pc", w_inst_addr, 32'h3000);
        chk("ori_we", {31'h0, w_grf_we}, 32'h1);
        chk("ori_addr", {27'h0, w_grf_addr}, 32'd1);
        chk("ori_data", w_grf_wdata, 32'h1234);
        nxt();
        chk("sw_be", {28'h0, m_data_byteen}, 32'hf);
        chk("sw_addr", m_data_addr, 32'h4);
        chk("sw_wd", m_data_wdata, 32'h1234);
        chk("sw_minst", m_inst_addr, 32'h3004);
        nxt();
        chk("sb_be", {28'h0, m_data_byteen}, 32'h8);
        chk("sb_wd", m_data_wdata, 32'h3434_3434);
        nxt();
        chk("beq_pc", macroscopic_pc, 32'h300c);
        chk("beq_we", {31'h0, w_grf_we}, 32'h0);
        nxt();
        chk("ds_pc", macroscopic_pc, 32'h3010);
        chk("ds_addr", {27'h0, w_grf_addr}, 32'd3);
        chk("ds_data", w_grf_wdata, 32'h55);
        nxt();
        chk("tgt_pc", macroscopic_pc, 32'h3040);
        chk("lw_data", w_grf_wdata, 32'h3400_1234);
        nxt();
        chk("ori5", w_grf_wdata, 32'h1401);
        nxt();
        chk("mtc0_we", {31'h0, w_grf_we}, 32'h0);
        nxt();
        chk("jal_pc", macroscopic_pc, 32'h304c);
        chk("jal_addr", {27'h0, w_grf_addr}, 32'd31);
        chk("jal_link", w_grf_wdata, 32'h3054);
        nxt();
        chk("jal_ds", w_grf_wdata, 32'h99);
        nxt();
        chk("jal_tgt", macroscopic_pc, 32'h3018);

        @(negedge clk);
        interrupt = 1'b1;
        #1;
        chk("int_pc", macroscopic_pc, 32'h301c);
        chk("int_sq_we", {31'h0, w_grf_we}, 32'h0);
        nxt();
        chk("hdl_pc", macroscopic_pc, 32'h4180);
        chk("hdl_be", {28'h0, m_data_byteen}, 32'hf);
        chk("hdl_addr", m_data_addr, 32'h7f20);
        interrupt = 1'b0;
        nxt();
        chk("cause", w_grf_wdata, 32'h8000_0000);
        nxt();
        chk("epc", w_grf_wdata, 32'h3018);
        nxt();
        chk("sr_exl", w_grf_wdata, 32'h1403);
        nxt();
        chk("eret_pc", macroscopic_pc, 32'h4190);
        chk("eret_we", {31'h0, w_grf_we}, 32'h0);
        nxt();
        chk("ret_pc", macroscopic_pc, 32'h3018);
        nxt();
        chk("ret_ds_pc", macroscopic_pc, 32'h301c);
        chk("ret_ds_data", w_grf_wdata, 32'h77);
        nxt();
        chk("ret_tgt", macroscopic_pc, 32'h3060);
        chk("sr_clr", w_grf_wdata, 32'h1401);
        chk("dm_7f20", dmem[12'hfc8], 32'h1234);
        nxt();
        chk("subu", w_grf_wdata, 32'hffff_edcc);
        nxt();
        chk("sw2_wd", m_data_wdata, 32'hffff_edcc);
        nxt();
        chk("lb", w_grf_wdata, 32'hffff_ffcc);
        nxt();
        chk("lhu", w_grf_wdata, 32'h0000_ffff);
        nxt();
        chk("slt", w_grf_wdata, 32'h1);
        nxt();
        chk("sltu_we", {31'h0, w_grf_we}, 32'h1);
        chk("sltu", w_grf_wdata, 32'h0);
        nxt();
        chk("sra", w_grf_wdata, 32'hffff_fedc);
        nxt();
        chk("lui", w_grf_wdata, 32'h8000_0000);
        nxt();
        chk("sw3_be", {28'h0, m_data_byteen}, 32'hf);

        reset = 1'b0;
        #1;
        chk("mid_rst_pc", macroscopic_pc, 32'h3000);
        chk("mid_rst_be", {28'h0, m_data_byteen}, 32'h0);
        chk("mid_rst_we", {31'h0, w_grf_we}, 32'h0);
        nxt();
        chk("hold_rst_pc", macroscopic_pc, 32'h3000);
        interrupt = 1'b1;
        reset = 1'b1;
        #1;
        chk("post_rst_we", {31'h0, w_grf_we}, 32'h1);
        nxt();
        chk("post_rst_pc", macroscopic_pc, 32'h3004);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
